conv_pool_sweeper: RTL

- Sequencer that sits directly downstream of the 28x28 5x5 convolution window stage.
- Drives that stage's window-position input over positions 0..783 in row-major order and samples its 8-bit combinational result.
- Applies optional ReLU and 2x2/stride-2 max pooling, and streams the 14x14 pooled map out over a valid/ready interface.
- Output feeds the next layer.

---
 rtl/conv_pool_sweeper_pkg.sv | 33 +++
 rtl/conv_pool_sweeper_if.sv | 22 ++
 rtl/conv_pool_sweeper_pool2x2_line.sv | 49 ++++
 rtl/conv_pool_sweeper.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/conv_pool_sweeper_pkg.sv
// Shared constants, state encoding and small datapath helpers for the
// conv-window sweeper and its 2x2 pooling line.
package conv_pool_sweeper_pkg;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int POS_W  = 21;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 8;
  localparam int POOL_W = IMG_W / 2;
  localparam int POOL_H = IMG_H / 2;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Negative (sign bit set) results clamp to zero when ReLU is enabled.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x,
                                             input logic en);
    return (en && x[DATA_W-1]) ? {DATA_W{1'b0}} : x;
  endfunction

endpackage

// File: rtl/conv_pool_sweeper_if.sv
// Conv-stage position/result bus plus the pooled valid/ready output stream.
interface conv_pool_sweeper_if;
  import conv_pool_sweeper_pkg::*;

  logic [POS_W-1:0]  conv_pos;
  logic [DATA_W-1:0] conv_out;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output conv_pos, out_data, out_idx, out_valid,
    input  conv_out, out_ready
  );

  modport slave (
    input  conv_pos, out_data, out_idx, out_valid,
    output conv_out, out_ready
  );

endinterface

// File: rtl/conv_pool_sweeper_pool2x2_line.sv
// Horizontal pair register plus half-width line buffer forming a 2x2 max pool;
// pooled_o is valid combinationally at odd-row/odd-column positions.
module pool2x2_line
  import conv_pool_sweeper_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              row_odd_i,
  input  logic [COL_W-1:0]  col_i,
  input  logic [DATA_W-1:0] v_i,
  output logic [DATA_W-1:0] pooled_o
);

  logic [DATA_W-1:0] pair_q;
  logic [DATA_W-1:0] pair_d;
  logic [DATA_W-1:0] line_q [POOL_W];
  logic [COL_W-2:0]  slot_s;
  logic [DATA_W-1:0] m_s;

  // Horizontal max, vertical max against the buffered even row, next pair value.
  always_comb begin
    slot_s   = col_i[COL_W-1:1];
    m_s      = umax(pair_q, v_i);
    pooled_o = umax(line_q[slot_s], m_s);
    if (!hold_i && !col_i[0]) begin
      pair_d = v_i;
    end else begin
      pair_d = pair_q;
    end
  end

  // Pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= {DATA_W{1'b0}};
    end else begin
      pair_q <= pair_d;
    end
  end

  // Even rows park their horizontal max until the odd row below arrives.
  always_ff @(posedge clk) begin
    if (!hold_i && col_i[0] && !row_odd_i) begin
      line_q[slot_s] <= m_s;
    end
  end

endmodule

// File: rtl/conv_pool_sweeper.sv
// Sweeps the conv window over every image position, applies ReLU and 2x2 max
// pooling, and streams the pooled map out over valid/ready.
module conv_pool_sweeper
  import conv_pool_sweeper_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  conv_pool_sweeper_if.master  bus,
  output logic                 busy,
  output logic                 done
);

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;

  logic              sweep_s, emit_pos_s, stall_s, advance_s, last_pos_s;
  logic              emit_fire_s, accept_s, begin_s;
  logic [DATA_W-1:0] v_s, pooled_s;

  assign sweep_s     = (state_q == ST_SWEEP);
  assign emit_pos_s  = sweep_s && row_q[0] && col_q[0];
  assign stall_s     = emit_pos_s && valid_q && !bus.out_ready;
  assign advance_s   = sweep_s && !stall_s;
  assign last_pos_s  = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
  assign emit_fire_s = emit_pos_s && !stall_s;
  assign accept_s    = valid_q && bus.out_ready;
  assign begin_s     = (state_q == ST_IDLE) && start;
  assign v_s         = relu(bus.conv_out, RELU_EN);

  assign bus.conv_pos  = pos_q;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;

  pool2x2_line u_pool (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_i    (!advance_s),
    .row_odd_i (row_q[0]),
    .col_i     (col_q),
    .v_i       (v_s),
    .pooled_o  (pooled_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN waits for the final pooled pixel to be taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SWEEP; else state_d = ST_IDLE;
      ST_SWEEP: if (advance_s && last_pos_s) state_d = ST_DRAIN; else state_d = ST_SWEEP;
      ST_DRAIN: if (!valid_q || bus.out_ready) state_d = ST_DONE; else state_d = ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_SWEEP: busy = 1'b1;
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Raster counters; the last position wraps everything back to zero.
  always_comb begin
    pos_d = pos_q;
    row_d = row_q;
    col_d = col_q;
    if (advance_s) begin
      if (last_pos_s) begin
        pos_d = {POS_W{1'b0}};
        row_d = {ROW_W{1'b0}};
        col_d = {COL_W{1'b0}};
      end else if (col_q == COL_W'(IMG_W - 1)) begin
        pos_d = pos_q + POS_W'(1);
        row_d = row_q + ROW_W'(1);
        col_d = {COL_W{1'b0}};
      end else begin
        pos_d = pos_q + POS_W'(1);
        col_d = col_q + COL_W'(1);
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Output register: a new emit overrides an accept so back-to-back has no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (emit_fire_s) begin
      valid_d = 1'b1;
      data_d  = pooled_s;
      idx_d   = cnt_q;
      cnt_d   = cnt_q + IDX_W'(1);
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else if (begin_s) begin
      cnt_d = {IDX_W{1'b0}};
    end else begin
      valid_d = valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= {POS_W{1'b0}};
      row_q   <= {ROW_W{1'b0}};
      col_q   <= {COL_W{1'b0}};
      cnt_q   <= {IDX_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule
